fc_state_tx: RTL and testbench

FC_STATE_TX -- requirements
Module: fc_state_tx

---
 rtl/fc_pkg.sv | 42 ++++
 rtl/fc_state_tx.sv | 88 ++++++++
 tb/tb_fc_state_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Fibre Channel port states and ordered-set encodings, shared by the
// transmit word generator and the receive-side decoder.
package fc;

  typedef enum logic [3:0] {
    LR1 = 4'd0,
    LR2 = 4'd1,
    LR3 = 4'd2,
    LF1 = 4'd3,
    LF2 = 4'd4,
    OL1 = 4'd5,
    OL2 = 4'd6,
    OL3 = 4'd7,
    AC  = 4'd8
  } state_t;

  localparam logic [31:0] PRIM_IDLE_WORD = 32'hBC95B5B5;
  localparam logic [31:0] PRIM_LR_WORD   = 32'hBC49BF49;
  localparam logic [31:0] PRIM_LRR_WORD  = 32'hBC35BF49;
  localparam logic [31:0] PRIM_NOS_WORD  = 32'hBC55BF45;
  localparam logic [31:0] PRIM_OLS_WORD  = 32'hBC358A55;
  localparam logic [3:0]  PRIM_K         = 4'b1000;

  // Ordered set a port transmits in each state; unknown encodings fall back to NOS.
  function automatic logic [31:0] prim_word(input state_t s);
    logic [31:0] w;
    case (s)
      LR1:     w = PRIM_LR_WORD;
      LR2:     w = PRIM_LRR_WORD;
      LR3:     w = PRIM_IDLE_WORD;
      LF1:     w = PRIM_OLS_WORD;
      LF2:     w = PRIM_NOS_WORD;
      OL1:     w = PRIM_OLS_WORD;
      OL2:     w = PRIM_LR_WORD;
      OL3:     w = PRIM_NOS_WORD;
      AC:      w = PRIM_IDLE_WORD;
      default: w = PRIM_NOS_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fc_state_tx.sv
// FC transmit word generator: emits the state's ordered set, or in AC
// user frames separated by a minimum IDLE run.
module fc_state_tx
  import fc::*;
#(
  parameter int IDLE_MIN = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  state_t      state,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_datak,
  output logic        tx_active
);

  localparam int CW = $clog2(IDLE_MIN + 1);

  logic [CW-1:0] entry_q, entry_d, gap_q, gap_d;
  logic          in_frame_q, in_frame_d, abort_q, abort_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [3:0]    out_datak_q, out_datak_d;
  logic          is_ac, abort, accept, send, idle_sent;

  always_comb begin
    is_ac     = (state == AC);
    tx_active = reset_n && is_ac && (entry_q == '0);
    // A frame cut short by leaving AC is drained to its EOF, never resumed.
    abort     = abort_q || (in_frame_q && !is_ac);
    in_ready  = reset_n && (abort || (in_frame_q ? tx_active
                                                 : (tx_active && gap_q == '0)));
    accept    = in_valid && in_ready;
    send      = accept && is_ac && !abort && (in_frame_q || in_startofpacket);
    idle_sent = is_ac && !send;

    in_frame_d = in_frame_q;
    abort_d    = abort_q;
    if (abort) begin
      in_frame_d = 1'b0;
      abort_d    = !(accept && in_endofpacket);
    end else if (accept) begin
      if (in_frame_q) in_frame_d = !in_endofpacket;
      else            in_frame_d = in_startofpacket && !in_endofpacket;
    end

    gap_d = gap_q;
    if (accept && in_endofpacket)     gap_d = CW'(IDLE_MIN);
    else if (idle_sent && gap_q != '0) gap_d = gap_q - CW'(1);

    entry_d = entry_q;
    if (!is_ac)                          entry_d = CW'(IDLE_MIN);
    else if (idle_sent && entry_q != '0) entry_d = entry_q - CW'(1);

    out_data_d  = prim_word(state);
    out_datak_d = PRIM_K;
    if (send) begin
      out_data_d  = in_data;
      out_datak_d = in_datak;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q     <= CW'(IDLE_MIN);
      gap_q       <= '0;
      in_frame_q  <= 1'b0;
      abort_q     <= 1'b0;
      out_data_q  <= PRIM_NOS_WORD;
      out_datak_q <= PRIM_K;
    end else begin
      entry_q     <= entry_d;
      gap_q       <= gap_d;
      in_frame_q  <= in_frame_d;
      abort_q     <= abort_d;
      out_data_q  <= out_data_d;
      out_datak_q <= out_datak_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_datak = out_datak_q;

endmodule

// File: tb/tb_fc_state_tx.sv
// Directed bench for fc_state_tx: vector tables plus hand-written streams.
module tb_fc_state_tx;
  import fc::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  state_t      state = LF2;
  logic [31:0] in_data = '0;
  logic [3:0]  in_datak = '0;
  logic        in_valid = 1'b0, in_startofpacket = 1'b0, in_endofpacket = 1'b0;
  logic        in_ready, tx_active;
  logic [31:0] out_data;
  logic [3:0]  out_datak;

  localparam logic [31:0] IDL = 32'hBC95B5B5;
  localparam logic [31:0] NOS = 32'hBC55BF45;
  localparam logic [31:0] LRW = 32'hBC49BF49;
  localparam logic [31:0] LRR = 32'hBC35BF49;

  fc_state_tx #(.IDLE_MIN(6)) dut (
    .clk(clk), .reset_n(reset_n), .state(state),
    .in_data(in_data), .in_datak(in_datak), .in_valid(in_valid),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_ready(in_ready), .out_data(out_data), .out_datak(out_datak),
    .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    state_t      st;
    logic        v, sof, eof;
    logic [31:0] d;
    logic [3:0]  k;
    logic [31:0] xd;
    logic [3:0]  xk;
    logic        xr, xa;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input state_t st, input logic v, input logic sof,
                              input logic eof, input logic [31:0] d, input logic [3:0] k,
                              input logic [31:0] xd, input logic [3:0] xk,
                              input logic xr, input logic xa);
    vec_t r;
    r.st = st; r.v = v; r.sof = sof; r.eof = eof; r.d = d; r.k = k;
    r.xd = xd; r.xk = xk; r.xr = xr; r.xa = xa;
    return r;
  endfunction

  // Drive a row at negedge, check handshake before the edge and out_* after it.
  task automatic cyc(input vec_t r, input string nm);
    @(negedge clk);
    state = r.st; in_valid = r.v; in_startofpacket = r.sof; in_endofpacket = r.eof;
    in_data = r.d; in_datak = r.k;
    #1;
    chk({nm, ".in_ready"}, in_ready, r.xr);
    chk({nm, ".tx_active"}, tx_active, r.xa);
    @(posedge clk); #1;
    chk({nm, ".out_data"}, out_data, r.xd);
    chk({nm, ".out_datak"}, out_datak, r.xk);
  endtask

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], $sformatf("%s[%0d]", nm, i));
    tbl.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      state = AC; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    end
  endtask

  logic [31:0] obs[$];
  typedef struct { logic [31:0] d; logic sof, eof; } word_t;
  word_t wq[$];

  initial begin
    // Reset held with LF2 and traffic offered: NOS, nothing accepted.
    in_valid = 1'b1; in_startofpacket = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst.out_data", out_data, NOS);
      chk("rst.out_datak", out_datak, 4'h8);
      chk("rst.in_ready", in_ready, 1'b0);
      chk("rst.tx_active", tx_active, 1'b0);
    end
    reset_n = 1'b1;

    // LR2 x3, then AC entry run of 6 IDLEs, a 3-word frame, gap, one-word frame.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(LR2, 1, 1, 0, 32'hA0000001, 4'h1, LRR, 4'h8, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(AC, 1, 1, 0, 32'hA0000001, 4'h1, IDL, 4'h8, 0, 0));
    tbl.push_back(mk(AC, 1, 1, 0, 32'hA0000001, 4'h1, 32'hA0000001, 4'h1, 1, 1));
    tbl.push_back(mk(AC, 1, 0, 0, 32'hA0000002, 4'h2, 32'hA0000002, 4'h2, 1, 1));
    tbl.push_back(mk(AC, 1, 0, 1, 32'hA0000003, 4'h3, 32'hA0000003, 4'h3, 1, 1));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(AC, 1, 1, 1, 32'hB0000001, 4'h0, IDL, 4'h8, 0, 1));
    tbl.push_back(mk(AC, 1, 1, 1, 32'hB0000001, 4'h0, 32'hB0000001, 4'h0, 1, 1));
    run_tbl("startup");

    // Two 4-word frames offered back to back.
    for (int f = 0; f < 2; f++)
      for (int w = 1; w <= 4; w++) begin
        word_t x;
        x.d = (f == 0 ? 32'hC0000000 : 32'hD0000000) + 32'(w);
        x.sof = (w == 1); x.eof = (w == 4);
        wq.push_back(x);
      end
    for (int c = 0; c < 40; c++) begin
      logic rdy;
      @(negedge clk);
      state = AC; in_valid = (wq.size() != 0); in_datak = 4'h0;
      if (wq.size() != 0) begin
        in_data = wq[0].d; in_startofpacket = wq[0].sof; in_endofpacket = wq[0].eof;
      end else begin
        in_startofpacket = 1'b0; in_endofpacket = 1'b0;
      end
      #1 rdy = in_ready;
      @(posedge clk); #1;
      obs.push_back(out_data);
      if (rdy && wq.size() != 0) void'(wq.pop_front());
    end
    begin
      int ip4, iq1, nidle;
      ip4 = -1; iq1 = -1; nidle = 0;
      for (int i = 0; i < obs.size(); i++) begin
        if (obs[i] == 32'hC0000004) ip4 = i;
        if (obs[i] == 32'hD0000001) iq1 = i;
      end
      chk("b2b.found", (ip4 > 2 && iq1 > ip4 && iq1 + 3 < obs.size()), 1'b1);
      if (ip4 > 2 && iq1 > ip4 && iq1 + 3 < obs.size()) begin
        for (int i = ip4 + 1; i < iq1; i++) if (obs[i] == IDL) nidle++;
        chk("b2b.gap_len", iq1 - ip4 - 1, 6);
        chk("b2b.gap_idles", nidle, 6);
        chk("b2b.f1_word1", obs[ip4-3], 32'hC0000001);
        chk("b2b.f2_word4", obs[iq1+3], 32'hD0000004);
      end
    end
    idle(8);

    // Abort: leave AC after word 2 of a 5-word frame, drain to EOF, re-enter AC.
    tbl.push_back(mk(AC,  1, 1, 0, 32'hE0000001, 4'h0, 32'hE0000001, 4'h0, 1, 1));
    tbl.push_back(mk(AC,  1, 0, 0, 32'hE0000002, 4'h0, 32'hE0000002, 4'h0, 1, 1));
    tbl.push_back(mk(OL2, 1, 0, 0, 32'hE0000003, 4'h0, LRW, 4'h8, 1, 0));
    tbl.push_back(mk(OL2, 1, 0, 0, 32'hE0000004, 4'h0, LRW, 4'h8, 1, 0));
    tbl.push_back(mk(OL2, 1, 0, 1, 32'hE0000005, 4'h0, LRW, 4'h8, 1, 0));
    tbl.push_back(mk(OL2, 1, 1, 0, 32'hF0000001, 4'h0, LRW, 4'h8, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(AC, 1, 1, 0, 32'hF0000001, 4'h0, IDL, 4'h8, 0, 0));
    tbl.push_back(mk(AC, 1, 1, 0, 32'hF0000001, 4'h0, 32'hF0000001, 4'h0, 1, 1));
    tbl.push_back(mk(AC, 1, 0, 1, 32'hF0000002, 4'h0, 32'hF0000002, 4'h0, 1, 1));
    run_tbl("abort");
    idle(8);

    // Reset pulse mid-frame; the tail must not be transmitted afterwards.
    cyc(mk(AC, 1, 1, 0, 32'h71000001, 4'h0, 32'h71000001, 4'h0, 1, 1), "rpulse.w1");
    cyc(mk(AC, 1, 0, 0, 32'h71000002, 4'h0, 32'h71000002, 4'h0, 1, 1), "rpulse.w2");
    reset_n = 1'b0;
    #1;
    chk("rpulse.out_data", out_data, NOS);
    chk("rpulse.out_datak", out_datak, 4'h8);
    chk("rpulse.in_ready", in_ready, 1'b0);
    chk("rpulse.tx_active", tx_active, 1'b0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tbl.push_back(mk(AC, 1, 0, 0, 32'h71000003, 4'h0, IDL, 4'h8, 0, 0));
    tbl.push_back(mk(AC, 1, 0, 0, 32'h71000003, 4'h0, IDL, 4'h8, 1, 1));
    tbl.push_back(mk(AC, 1, 0, 1, 32'h71000004, 4'h0, IDL, 4'h8, 1, 1));
    tbl.push_back(mk(AC, 0, 0, 0, 32'h0, 4'h0, IDL, 4'h8, 0, 1));
    // Undefined encoding, then a one-word frame followed by another.
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(state_t'(4'hF), 0, 0, 0, 32'h0, 4'h0, NOS, 4'h8, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(AC, 1, 1, 1, 32'h81000001, 4'h5, IDL, 4'h8, 0, 0));
    tbl.push_back(mk(AC, 1, 1, 1, 32'h81000001, 4'h5, 32'h81000001, 4'h5, 1, 1));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(AC, 1, 1, 1, 32'h82000001, 4'h6, IDL, 4'h8, 0, 1));
    tbl.push_back(mk(AC, 1, 1, 1, 32'h82000001, 4'h6, 32'h82000001, 4'h6, 1, 1));
    tbl.push_back(mk(AC, 0, 0, 0, 32'h0, 4'h0, IDL, 4'h8, 0, 1));
    run_tbl("tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
